soc_audio_clock_gen: RTL and testbench
======================================

Name: soc_audio_clock_gen

Overview:
- Parametrised digital audio clock generator, successor to the fixed single-output audio PLL wrapper.
- Runs on the PLL-derived MCLK (12.288 MHz nominal).
- Derives BCLK, LRCLK/frame sync and per-slot timing strobes for I2S/TDM codecs, with runtime-programmable MCLK:BCLK ratio.
- Ratio changes are glitch-free, taking effect only at frame boundaries, with a frame-based lock indicator.
- Sits between the audio PLL and the I2S serialiser/deserialiser.

Parameters:
- SLOT_WIDTH, 32, BCLK periods per slot (>=2).
- NUM_SLOTS, 2, slots per frame (2 = I2S stereo, >2 = TDM).
- DIV_W, 8, width of ratio configuration.
- DEFAULT_DIV, 4, MCLK cycles per BCLK after reset (12.288 MHz / 4 = 3.072 MHz = 48 kHz x 64).
- LOCK_FRAMES, 4, completed frames at a stable ratio before locked asserts.

Ports:
- refclk  in  1  MCLK from audio PLL; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run generator; 0 forces IDLE.
- div_cfg  in  DIV_W  requested MCLK:BCLK ratio N.
- div_load  in  1  one-cycle strobe capturing div_cfg.
- bclk  out  1  bit clock.
- lrclk  out  1  word select / frame sync.
- slot_idx  out  clog2(NUM_SLOTS)  current slot.
- bit_idx  out  clog2(SLOT_WIDTH)  current bit within slot.
- bclk_rise  out  1  one-cycle strobe: bclk goes 0->1 at this edge.
- bclk_fall  out  1  one-cycle strobe: bclk goes 1->0 at this edge.
- frame_start  out  1  one-cycle strobe: first cycle of slot 0, bit 0.
- locked  out  1  ratio stable for LOCK_FRAMES frames.

Behaviour:
- Reset values: all outputs 0. Active divider = DEFAULT_DIV, pending divider = DEFAULT_DIV, FSM = IDLE.
- Effective N = max(div_cfg, 2); values 0 and 1 are clamped to 2.
- Counters:
  - phase_cnt runs 0..N-1.
  - bclk = 0 for phase_cnt < ceil(N/2), else 1. Odd N gives a longer low phase.
  - bit_idx increments on phase_cnt wrap.
  - slot_idx increments on bit_idx wrap (SLOT_WIDTH-1 -> 0).
  - Frame boundary = wrap at slot NUM_SLOTS-1, bit SLOT_WIDTH-1, phase N-1.
  - Frame length = N x SLOT_WIDTH x NUM_SLOTS refclk cycles.
- All outputs are registered. Strobes are high exactly in the refclk cycle in which the registered bclk/slot value first shows its new state.
- lrclk:
  - NUM_SLOTS == 2: lrclk = slot_idx (0 = left, 1 = right).
  - NUM_SLOTS > 2: lrclk high only during slot 0, bit 0 (one-BCLK frame-sync pulse).
- FSM:
  - IDLE: outputs at reset values, counters cleared.
  - IDLE -> SYNC when enable = 1. The first cycle in SYNC is phase 0, bit 0, slot 0, and frame_start = 1.
  - SYNC -> LOCKED when the frame-completed counter reaches LOCK_FRAMES. locked rises coincident with frame_start of frame LOCK_FRAMES, where the first frame is frame 0.
  - Any state -> IDLE when enable = 0, at the next edge. Counters and outputs are cleared. No frame completion.
- div_load:
  - Captures effective N into the pending register; the last load before a boundary wins.
  - In IDLE: the active divider is updated immediately.
  - In SYNC/LOCKED: the pending value is applied at the next frame boundary. If it differs from the active value, locked drops at that boundary, the FSM goes to SYNC and the frame count restarts at 0. An equal value is a no-op.
- div_load and enable deasserting in the same cycle: the load is captured into the active divider; the FSM goes to IDLE.
- Mid-operation reset: asynchronous clear to reset values; the pending load is discarded.

Optional Feature:
- Macro AUDIO_CLK_I2S_DELAY_EN.
- Defined: lrclk leads the slot boundary by one BCLK, per Philips I2S. lrclk changes at the bclk_fall of bit SLOT_WIDTH-1 of the previous slot; in TDM mode the sync pulse occupies the last bit of slot NUM_SLOTS-1. Counters and strobes are unchanged.
- Undefined: left-justified alignment as described in Behaviour.

Test Plan:
- Reset, enable = 1, defaults (N=4, 32x2) -> bclk period 4 refclk (2 low / 2 high); frame_start every 256 cycles; lrclk toggles every 128 cycles; locked rises at the 4th frame_start after the first (cycle 1024 relative to the first frame_start).
- div_load with div_cfg=5 mid-frame while LOCKED -> period unchanged until the frame boundary, then bclk 3 low / 2 high and frame = 320 cycles; locked drops at the boundary and returns after 4 frames.
- div_cfg=0, then div_cfg=1, load in IDLE -> N=2, bclk toggles every cycle after enable; two loads (6 then 8) in one frame -> only 8 applied.
- NUM_SLOTS=8, SLOT_WIDTH=32, N=2 -> lrclk high for 2 cycles per 512-cycle frame; slot_idx cycles 0..7.
- enable dropped mid-slot 1 -> next cycle all outputs 0; re-enable restarts at slot 0, bit 0 with frame_start and locked=0. rst_n asserted mid-frame -> immediate clear; active div = DEFAULT_DIV.
- With AUDIO_CLK_I2S_DELAY_EN, N=4 stereo -> lrclk rises 4 refclk cycles before slot_idx changes to 1.

Source files
------------

// File: rtl/soc_audio_clock_gen.sv
// Audio clock generator: BCLK, LRCLK/frame sync and slot/bit strobes from MCLK.
// Optional macro AUDIO_CLK_I2S_DELAY_EN moves lrclk one BCLK early (Philips I2S).
module soc_audio_clock_gen #(
    parameter int SLOT_WIDTH  = 32,
    parameter int NUM_SLOTS   = 2,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4,
    parameter int LOCK_FRAMES = 4
) (
    input  logic                          refclk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [DIV_W-1:0]              div_cfg,
    input  logic                          div_load,
    output logic                          bclk,
    output logic                          lrclk,
    output logic [$clog2(NUM_SLOTS)-1:0]  slot_idx,
    output logic [$clog2(SLOT_WIDTH)-1:0] bit_idx,
    output logic                          bclk_rise,
    output logic                          bclk_fall,
    output logic                          frame_start,
    output logic                          locked
);

    localparam int SL_W = $clog2(NUM_SLOTS);
    localparam int BIT_W = $clog2(SLOT_WIDTH);
    localparam int FR_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [DIV_W:0] ONE_X = 1;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        LOCKED
    } state_t;

    state_t state_q, state_d;

    logic [DIV_W-1:0] active_q, active_d;
    logic [DIV_W-1:0] pending_q, pending_d;
    logic [DIV_W-1:0] phase_q, phase_d;
    logic [DIV_W-1:0] eff_div, load_div;
    logic [DIV_W:0]   half;
    logic [BIT_W-1:0] bit_d;
    logic [SL_W-1:0]  slot_d;
    logic [FR_W-1:0]  frames_q, frames_d;
    logic             ph_wrap, bit_wrap, slot_wrap;
    logic             bclk_d, lrclk_d, rise_d, fall_d, fs_d, locked_d;

    function automatic logic lr_of(logic [BIT_W-1:0] b, logic [SL_W-1:0] s);
`ifdef AUDIO_CLK_I2S_DELAY_EN
        if (NUM_SLOTS == 2)
            return (b == BIT_W'(SLOT_WIDTH - 1)) ? ~s[0] : s[0];
        return (s == SL_W'(NUM_SLOTS - 1)) && (b == BIT_W'(SLOT_WIDTH - 1));
`else
        if (NUM_SLOTS == 2)
            return s[0];
        return (s == '0) && (b == '0);
`endif
    endfunction

    assign eff_div   = (div_cfg < DIV_W'(2)) ? DIV_W'(2) : div_cfg;
    assign load_div  = div_load ? eff_div : pending_q;
    assign ph_wrap   = (phase_q == active_q - DIV_W'(1));
    assign bit_wrap  = (bit_idx == BIT_W'(SLOT_WIDTH - 1));
    assign slot_wrap = (slot_idx == SL_W'(NUM_SLOTS - 1));

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        pending_d = pending_q;
        phase_d   = phase_q;
        bit_d     = bit_idx;
        slot_d    = slot_idx;
        frames_d  = frames_q;
        half      = '0;
        bclk_d    = 1'b0;
        lrclk_d   = 1'b0;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        fs_d      = 1'b0;
        locked_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                phase_d  = '0;
                bit_d    = '0;
                slot_d   = '0;
                frames_d = '0;
                if (div_load) begin
                    active_d  = eff_div;
                    pending_d = eff_div;
                end
                if (enable) begin
                    state_d = SYNC;
                    fs_d    = 1'b1;
                    lrclk_d = lr_of('0, '0);
                end
            end
            default: begin
                if (!enable) begin
                    state_d  = IDLE;
                    phase_d  = '0;
                    bit_d    = '0;
                    slot_d   = '0;
                    frames_d = '0;
                    if (div_load) begin
                        active_d  = eff_div;
                        pending_d = eff_div;
                    end
                end else begin
                    pending_d = load_div;
                    phase_d   = ph_wrap ? '0 : phase_q + DIV_W'(1);
                    if (ph_wrap) begin
                        bit_d = bit_wrap ? '0 : bit_idx + BIT_W'(1);
                        if (bit_wrap)
                            slot_d = slot_wrap ? '0 : slot_idx + SL_W'(1);
                    end
                    // Frame boundary: the only point where the ratio may change
                    if (ph_wrap && bit_wrap && slot_wrap) begin
                        fs_d = 1'b1;
                        if (load_div != active_q) begin
                            active_d = load_div;
                            frames_d = '0;
                            state_d  = SYNC;
                        end else if (state_q == SYNC) begin
                            if (frames_q == FR_W'(LOCK_FRAMES - 1))
                                state_d = LOCKED;
                            frames_d = frames_q + FR_W'(1);
                        end
                    end
                    half     = ({1'b0, active_d} + ONE_X) >> 1;
                    bclk_d   = ({1'b0, phase_d} >= half);
                    rise_d   = bclk_d & ~bclk;
                    fall_d   = ~bclk_d & bclk;
                    lrclk_d  = lr_of(bit_d, slot_d);
                    locked_d = (state_d == LOCKED);
                end
            end
        endcase
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            active_q    <= DIV_W'(DEFAULT_DIV);
            pending_q   <= DIV_W'(DEFAULT_DIV);
            phase_q     <= '0;
            frames_q    <= '0;
            bit_idx     <= '0;
            slot_idx    <= '0;
            bclk        <= 1'b0;
            lrclk       <= 1'b0;
            bclk_rise   <= 1'b0;
            bclk_fall   <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            phase_q     <= phase_d;
            frames_q    <= frames_d;
            bit_idx     <= bit_d;
            slot_idx    <= slot_d;
            bclk        <= bclk_d;
            lrclk       <= lrclk_d;
            bclk_rise   <= rise_d;
            bclk_fall   <= fall_d;
            frame_start <= fs_d;
            locked      <= locked_d;
        end
    end

endmodule

// File: tb/tb_soc_audio_clock_gen.sv
// Bench for soc_audio_clock_gen: stereo and small TDM instance vs frame-position model.
// Define AUDIO_CLK_I2S_DELAY_EN here too when building the delayed variant.
module tb_soc_audio_clock_gen;

    localparam int SWS [2] = '{32, 4};
    localparam int NSS [2] = '{2, 4};
    localparam int LOCKF = 4;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] div_cfg = 8'd4;
    logic       div_load = 1'b0;

    logic       bclk0, lr0, ri0, fa0, fs0, lk0, slot0;
    logic [4:0] bit0;
    logic       bclk1, lr1, ri1, fa1, fs1, lk1;
    logic [1:0] slot1, bit1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    soc_audio_clock_gen u_st (
        .refclk(refclk), .rst_n(rst_n), .enable(enable),
        .div_cfg(div_cfg), .div_load(div_load),
        .bclk(bclk0), .lrclk(lr0), .slot_idx(slot0), .bit_idx(bit0),
        .bclk_rise(ri0), .bclk_fall(fa0), .frame_start(fs0), .locked(lk0)
    );

    soc_audio_clock_gen #(.SLOT_WIDTH(4), .NUM_SLOTS(4)) u_tdm (
        .refclk(refclk), .rst_n(rst_n), .enable(enable),
        .div_cfg(div_cfg), .div_load(div_load),
        .bclk(bclk1), .lrclk(lr1), .slot_idx(slot1), .bit_idx(bit1),
        .bclk_rise(ri1), .bclk_fall(fa1), .frame_start(fs1), .locked(lk1)
    );

    always #5 refclk = ~refclk;
    always @(posedge refclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(int lk, int fs, int fa, int ri,
                                         int lr, int bc, int s, int b);
        return 32'((lk << 21) | (fs << 20) | (fa << 19) | (ri << 18) |
                   (lr << 17) | (bc << 16) | (s << 8) | b);
    endfunction

    // Model: position t within the current frame, plus ratio/lock bookkeeping
    int m_run[2], m_t[2], m_n[2], m_pend[2], m_frames[2];
    int m_lk[2], m_fs[2], m_ri[2], m_fa[2];

    function automatic int bclk_of(int i);
        if (m_run[i] == 0) return 0;
        return ((m_t[i] % m_n[i]) >= (m_n[i] + 1) / 2) ? 1 : 0;
    endfunction

    function automatic logic [31:0] exp_of(int i);
        int b, s, lr;
        if (m_run[i] == 0) return 32'h0;
        b = (m_t[i] / m_n[i]) % SWS[i];
        s = m_t[i] / (m_n[i] * SWS[i]);
`ifdef AUDIO_CLK_I2S_DELAY_EN
        if (NSS[i] == 2)
            lr = (b == SWS[i] - 1) ? (s + 1) % 2 : s;
        else
            lr = (s == NSS[i] - 1 && b == SWS[i] - 1) ? 1 : 0;
`else
        if (NSS[i] == 2)
            lr = s;
        else
            lr = (s == 0 && b == 0) ? 1 : 0;
`endif
        return pack(m_lk[i], m_fs[i], m_fa[i], m_ri[i], lr, bclk_of(i), s, b);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_t[i] = 0; m_n[i] = 4; m_pend[i] = 4;
            m_frames[i] = 0; m_lk[i] = 0; m_fs[i] = 0;
            m_ri[i] = 0; m_fa[i] = 0;
        end
    endtask

    task automatic model_step(int i);
        int eff, ob, nb;
        eff = (div_cfg < 2) ? 2 : int'(div_cfg);
        ob = bclk_of(i);
        m_fs[i] = 0;
        if (m_run[i] == 0) begin
            if (div_load) begin m_n[i] = eff; m_pend[i] = eff; end
            if (enable) begin
                m_run[i] = 1; m_t[i] = 0; m_frames[i] = 0;
                m_lk[i] = 0; m_fs[i] = 1;
            end
        end else if (!enable) begin
            m_run[i] = 0; m_lk[i] = 0;
            if (div_load) begin m_n[i] = eff; m_pend[i] = eff; end
        end else begin
            if (div_load) m_pend[i] = eff;
            m_t[i]++;
            if (m_t[i] == m_n[i] * SWS[i] * NSS[i]) begin
                m_t[i] = 0; m_fs[i] = 1;
                if (m_pend[i] != m_n[i]) begin
                    m_n[i] = m_pend[i]; m_frames[i] = 0; m_lk[i] = 0;
                end else begin
                    m_frames[i]++;
                    if (m_frames[i] >= LOCKF) m_lk[i] = 1;
                end
            end
        end
        nb = bclk_of(i);
        m_ri[i] = (m_run[i] != 0 && nb == 1 && ob == 0) ? 1 : 0;
        m_fa[i] = (m_run[i] != 0 && nb == 0 && ob == 1) ? 1 : 0;
    endtask

    initial model_reset();

    always @(posedge refclk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    always @(negedge refclk) begin
        if (chk_en) begin
            check("stereo", pack(lk0, fs0, fa0, ri0, lr0, bclk0, slot0, bit0),
                  exp_of(0));
            check("tdm", pack(lk1, fs1, fa1, ri1, lr1, bclk1, slot1, bit1),
                  exp_of(1));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic wait_ev(input string tag, input bit on_lock,
                           input int lim, output int at);
        at = -1;
        for (int k = 0; k < lim; k++) begin
            @(negedge refclk);
            if (on_lock ? lk0 : fs0) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic load(input logic [7:0] v);
        div_cfg = v;
        div_load = 1'b1;
        tick(1);
        div_load = 1'b0;
    endtask

    int t0, t1, t2, t3, t4, t5;

    initial begin
        #2 rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick(2);
        check("reset_out", pack(lk0, fs0, fa0, ri0, lr0, bclk0, slot0, bit0), 0);

        enable = 1'b1;
        wait_ev("fs_first", 0, 10, t0);
        wait_ev("lock", 1, 2000, t1);
        check("lock_lat", t1 - t0, 1024);
        wait_ev("fs_n4", 0, 400, t2);
        check("frame_len4", t2 - t1, 256);

        tick(50);
        load(8'd5);
        check("lock_hold", lk0, 1);
        wait_ev("fs_pend", 0, 400, t3);
        check("frame_len_pend", t3 - t2, 256);
        check("lock_drop", lk0, 0);
        wait_ev("fs_n5", 0, 400, t4);
        check("frame_len5", t4 - t3, 320);
        wait_ev("relock", 1, 2000, t5);
        check("relock_lat", t5 - t3, 1280);

        tick(7);
        enable = 1'b0;
        load(8'd0);
        load(8'd1);
        enable = 1'b1;
        wait_ev("fs_n2a", 0, 10, t0);
        wait_ev("fs_n2b", 0, 200, t1);
        check("frame_len2", t1 - t0, 128);

        tick(10);
        load(8'd6);
        tick(20);
        load(8'd8);
        wait_ev("fs_n8a", 0, 200, t2);
        wait_ev("fs_n8b", 0, 700, t3);
        check("frame_len8", t3 - t2, 512);

        tick(8 * 32 + 20);
        enable = 1'b0;
        tick(1);
        @(negedge refclk);
        check("en_drop", pack(lk0, fs0, fa0, ri0, lr0, bclk0, slot0, bit0), 0);
        #1 enable = 1'b1;
        wait_ev("fs_reen", 0, 10, t4);
        check("reen_lock", lk0, 0);

        tick(77);
        #1 rst_n = 1'b0;
        #2;
        check("rst_async", pack(lk0, fs0, fa0, ri0, lr0, bclk0, slot0, bit0), 0);
        rst_n = 1'b1;
        wait_ev("fs_rst_a", 0, 10, t0);
        wait_ev("fs_rst_b", 0, 400, t1);
        check("frame_len_rst", t1 - t0, 256);

        for (int k = 0; k < 25000; k++) begin
            tick(1);
            div_load = 1'b0;
            if ($urandom_range(0, 999) < 2) begin
                div_cfg = 8'($urandom_range(0, 9));
                div_load = 1'b1;
            end
            if (enable && $urandom_range(0, 1999) == 0)
                enable = 1'b0;
            else if (!enable && $urandom_range(0, 19) == 0)
                enable = 1'b1;
            if ($urandom_range(0, 4999) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        tick(1);
        div_load = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
